// File: rtl/hold_repeat_ticker.sv
// Multi-channel hold-to-repeat tick generator: an optional press tick, a first tick
// after a long hold, then periodic ticks while the button stays held.
module hold_repeat_ticker #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 25,
  parameter int FIRST_CNT  = 25000000,
  parameter int REPEAT_CNT = 5000000,
  parameter int IMMEDIATE  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] hold,
  input  logic [N_CH-1:0] rep_en,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] active,
  output logic            any_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_REPEAT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] FIRST_TC  = CNT_W'(FIRST_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
  localparam logic             IMM_TICK  = (IMMEDIATE != 0);

  state_t [N_CH-1:0]            state_q, state_d;
  logic   [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic   [N_CH-1:0]            tick_q, tick_d;
  logic   [N_CH-1:0]            active_q, active_d;
  logic                         any_tick_q, any_tick_d;

  // Release beats rep_en drop, which beats terminal count, so a release on the
  // terminal edge swallows that tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tick_d   = '0;
    active_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (state_q[i])
        S_IDLE: begin
          cnt_d[i] = '0;
          if (hold[i]) begin
            state_d[i] = S_FIRST;
            tick_d[i]  = IMM_TICK;
          end
        end
        S_FIRST: begin
          if (!hold[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == FIRST_TC) begin
            tick_d[i]  = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = rep_en[i] ? S_REPEAT : S_DONE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!hold[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (!rep_en[i]) begin
            state_d[i] = S_DONE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REPEAT_TC) begin
            tick_d[i] = 1'b1;
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_DONE: begin
          cnt_d[i] = '0;
          if (!hold[i]) state_d[i] = S_IDLE;
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      active_d[i] = (state_d[i] == S_FIRST) || (state_d[i] == S_REPEAT);
    end
    any_tick_d = |tick_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      tick_q     <= '0;
      active_q   <= '0;
      any_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      any_tick_q <= any_tick_d;
    end
  end

  assign tick     = tick_q;
  assign active   = active_q;
  assign any_tick = any_tick_q;

endmodule

// File: tb/tb_hold_repeat_ticker.sv
// Directed bench for hold_repeat_ticker: two channels, FIRST_CNT=5, REPEAT_CNT=3,
// one instance with the press tick enabled and one without.
module tb_hold_repeat_ticker;

  localparam int N_CH       = 2;
  localparam int CNT_W      = 4;
  localparam int FIRST_CNT  = 5;
  localparam int REPEAT_CNT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] hold;
  logic [N_CH-1:0] rep_en;
  logic [N_CH-1:0] tick, active;
  logic            any_tick;
  logic [N_CH-1:0] tick_n, active_n;
  logic            any_tick_n;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  hold_repeat_ticker #(
    .N_CH(N_CH), .CNT_W(CNT_W), .FIRST_CNT(FIRST_CNT),
    .REPEAT_CNT(REPEAT_CNT), .IMMEDIATE(1)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .rep_en(rep_en),
    .tick(tick), .active(active), .any_tick(any_tick)
  );

  hold_repeat_ticker #(
    .N_CH(N_CH), .CNT_W(CNT_W), .FIRST_CNT(FIRST_CNT),
    .REPEAT_CNT(REPEAT_CNT), .IMMEDIATE(0)
  ) dut_noimm (
    .clk(clk), .rst(rst), .hold(hold), .rep_en(rep_en),
    .tick(tick_n), .active(active_n), .any_tick(any_tick_n)
  );

  always #5 clk = ~clk;

  initial begin
    if (FIRST_CNT < 2 || REPEAT_CNT < 2 || (1 << CNT_W) <= FIRST_CNT ||
        (1 << CNT_W) <= REPEAT_CNT)
      $fatal(1, "illegal parameter set");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    hold   = '0;
    rep_en = '1;
    step();
    step();
    rst = 1'b1;
  endtask

  // Tick expected d edges after the press edge while held continuously with rep_en=1.
  function automatic logic exp_tick(int d, bit imm);
    if (d < 0) return 1'b0;
    if (d == 0) return imm;
    return (d >= FIRST_CNT) && ((d - FIRST_CNT) % REPEAT_CNT == 0);
  endfunction

  initial begin
    rst    = 1'b0;
    hold   = '0;
    rep_en = '1;
    #1;
    chk("reset_tick", 32'(tick), 0);
    chk("reset_active", 32'(active), 0);
    chk("reset_any", 32'(any_tick), 0);
    step();
    rst = 1'b1;

    // Continuous hold with repeat: ticks at 0,5,8,11,14 then release
    for (int e = 0; e < 15; e++) begin
      hold[0] = 1'b1;
      step();
      chk($sformatf("s1_tick e%0d", e), 32'(tick[0]),
          32'((e == 0) || (e == 5) || (e == 8) || (e == 11) || (e == 14)));
      chk($sformatf("s1_active e%0d", e), 32'(active[0]), 1);
    end
    hold[0] = 1'b0;
    for (int e = 15; e < 19; e++) begin
      step();
      chk($sformatf("s1_rel_tick e%0d", e), 32'(tick[0]), 0);
      chk($sformatf("s1_rel_active e%0d", e), 32'(active[0]), 0);
    end

    // Short press released before edge 4, re-press at edge 10
    do_reset();
    for (int e = 0; e < 17; e++) begin
      hold[0] = (e < 4) || (e >= 10);
      step();
      chk($sformatf("s2_tick e%0d", e), 32'(tick[0]), 32'((e == 0) || (e == 10) || (e == 15)));
    end

    // One-shot: rep_en=0, ticks at 0 and 5 only, then DONE
    do_reset();
    rep_en[0] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      hold[0] = 1'b1;
      step();
      chk($sformatf("s3_tick e%0d", e), 32'(tick[0]), 32'((e == 0) || (e == 5)));
      chk($sformatf("s3_active e%0d", e), 32'(active[0]), 32'(e < 5));
    end
    hold[0] = 1'b0;
    step();
    chk("s3_release_tick", 32'(tick[0]), 0);
    hold[0] = 1'b1;
    step();
    chk("s3_repress_tick", 32'(tick[0]), 1);
    chk("s3_repress_active", 32'(active[0]), 1);

    // Release on the FIRST terminal edge swallows the tick
    do_reset();
    for (int e = 0; e < 7; e++) begin
      hold[0] = (e < 5);
      step();
      chk($sformatf("s4a_tick e%0d", e), 32'(tick[0]), 32'(e == 0));
      chk($sformatf("s4a_active e%0d", e), 32'(active[0]), 32'(e < 5));
    end

    // Release on the first REPEAT terminal edge (edge 8) swallows the tick
    do_reset();
    for (int e = 0; e < 10; e++) begin
      hold[0] = (e < 8);
      step();
      chk($sformatf("s4b_tick e%0d", e), 32'(tick[0]), 32'((e == 0) || (e == 5)));
      chk($sformatf("s4b_active e%0d", e), 32'(active[0]), 32'(e < 8));
    end

    // Channel 1 pressed two edges after channel 0, with and without press tick
    do_reset();
    for (int e = 0; e < 15; e++) begin
      hold = {1'(e >= 2), 1'b1};
      step();
      chk($sformatf("s5_tick0 e%0d", e), 32'(tick[0]), 32'(exp_tick(e, 1'b1)));
      chk($sformatf("s5_tick1 e%0d", e), 32'(tick[1]), 32'(exp_tick(e - 2, 1'b1)));
      chk($sformatf("s5_any e%0d", e), 32'(any_tick),
          32'(exp_tick(e, 1'b1) | exp_tick(e - 2, 1'b1)));
      chk($sformatf("s5n_tick0 e%0d", e), 32'(tick_n[0]), 32'(exp_tick(e, 1'b0)));
      chk($sformatf("s5n_tick1 e%0d", e), 32'(tick_n[1]), 32'(exp_tick(e - 2, 1'b0)));
      chk($sformatf("s5n_any e%0d", e), 32'(any_tick_n),
          32'(exp_tick(e, 1'b0) | exp_tick(e - 2, 1'b0)));
    end

    // Async reset mid-REPEAT, then release with hold still high
    do_reset();
    for (int e = 0; e < 9; e++) begin
      hold[0] = 1'b1;
      step();
    end
    chk("s6_pre_tick", 32'(tick[0]), 1);
    chk("s6_pre_any", 32'(any_tick), 1);
    rst = 1'b0;
    #1;
    chk("s6_async_tick", 32'(tick), 0);
    chk("s6_async_active", 32'(active), 0);
    chk("s6_async_any", 32'(any_tick), 0);
    chk("s6_async_active_n", 32'(active_n), 0);
    #1;
    rst = 1'b1;
    for (int e = 0; e < 7; e++) begin
      step();
      chk($sformatf("s6_tick e%0d", e), 32'(tick[0]), 32'((e == 0) || (e == 5)));
      chk($sformatf("s6_active e%0d", e), 32'(active[0]), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
